lam_queue: RTL

Parametrised load/store unit sitting between the decoder and data memory, successor to the fixed two-slot LAM. Accepts LB/LH/LW/LBU/LHU/SB/SH/SW operations into an in-order queue of `DEPTH` entries, issues them one at a time to memory over a request/ready handshake of arbitrary latency, and writes load results back to the register bank. Raises `halt` to stall the decoder on queue-full or on read-after-load hazards against any pending load.

---
 rtl/lam_queue.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/lam_queue.sv
// lam_queue: in-order load/store queue between decoder and data memory.
// Entries issue one at a time over a req/ready handshake; load results return
// on the wb_* port. Define LAM_MISALIGN_TRAP_EN to drop misaligned H/W
// accesses and report them on misalign_err/misalign_addr instead.
module lam_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset_in,
    input  logic            lam_new,
    input  logic            read_write,
    input  logic [2:0]      lam_type,
    input  logic [4:0]      sel_out,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [4:0]      deco_rs1,
    input  logic [4:0]      deco_rs2,
    output logic            halt,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_err,
    output logic [XLEN-1:0] misalign_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [DEPTH-1:0] q_store;
    logic [2:0]       q_type [DEPTH];
    logic [4:0]       q_rd   [DEPTH];
    logic [XLEN-1:0]  q_addr [DEPTH];
    logic [XLEN-1:0]  q_data [DEPTH];
    logic [AW-1:0]    head, tail;
    logic [AW:0]      count;
    logic [0:0]       state;

    logic            full, hazard, push, pop, misaligned, trap, wb_fire;
    logic            h_store;
    logic [2:0]      h_type;
    logic [4:0]      h_rd;
    logic [XLEN-1:0] h_addr, h_data, h_wdata, ld_data;
    logic [3:0]      h_be;
    logic [7:0]      b_sel;
    logic [15:0]     hw_sel;

    assign h_store = q_store[head];
    assign h_type  = q_type[head];
    assign h_rd    = q_rd[head];
    assign h_addr  = q_addr[head];
    assign h_data  = q_data[head];

    assign full    = count == (AW+1)'(DEPTH);
    assign halt    = (lam_new && full) || hazard;
    assign push    = lam_new && !halt;
`ifdef LAM_MISALIGN_TRAP_EN
    assign misaligned = (h_type[1:0] == 2'b01 && h_addr[0]) || (h_type[1] && h_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif
    assign trap    = state == IDLE && count != '0 && misaligned;
    assign wb_fire = state == REQ && mem_ready && !h_store && h_rd != 5'd0;
    assign pop     = trap || (state == REQ && mem_ready);

    // read-after-load hazard against every occupied slot holding a load, in flight or not
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, AW'(AW'(i) - head)} < count && !q_store[i] && q_rd[i] != 5'd0 &&
                (q_rd[i] == deco_rs1 || q_rd[i] == deco_rs2))
                hazard = 1'b1;
    end

    // lane enables, replicated store data and extended load data for the head entry
    always_comb begin
        h_be    = h_type[1] ? 4'b1111 : h_type[0] ? (h_addr[1] ? 4'b1100 : 4'b0011) : 4'b0001 << h_addr[1:0];
        h_wdata = h_type[1] ? h_data : h_type[0] ? {2{h_data[15:0]}} : {4{h_data[7:0]}};
        b_sel   = mem_rdata[{h_addr[1:0], 3'b000} +: 8];
        hw_sel  = h_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ld_data = h_type[1] ? mem_rdata
                : h_type[0] ? {{16{hw_sel[15] & ~h_type[2]}}, hw_sel}
                : {{24{b_sel[7] & ~h_type[2]}}, b_sel};
    end

    // queue storage: the tail slot captures an accepted operation
    always_ff @(posedge clk) begin
        if (push) begin
            q_store[tail] <= read_write;
            q_type[tail]  <= lam_type;
            q_rd[tail]    <= sel_out;
            q_addr[tail]  <= addr;
            q_data[tail]  <= st_data;
        end
    end

    // circular pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop) head <= head + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // issue FSM: latch the head onto the bus and hold it until mem_ready
    always_ff @(posedge clk) begin
        if (reset_in) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else if (state == IDLE) begin
            if (count != '0 && !misaligned) begin
                state     <= REQ;
                mem_req   <= 1'b1;
                mem_we    <= h_store;
                mem_addr  <= {h_addr[XLEN-1:2], 2'b00};
                mem_be    <= h_be;
                mem_wdata <= h_wdata;
            end
        end else if (mem_ready) begin
            state   <= IDLE;
            mem_req <= 1'b0;
        end
    end

    // load writeback, valid for the single cycle after the completing edge
    always_ff @(posedge clk) begin
        if (reset_in) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= wb_fire;
            if (wb_fire) begin
                wb_rd   <= h_rd;
                wb_data <= ld_data;
            end
        end
    end

`ifdef LAM_MISALIGN_TRAP_EN
    // one-cycle trap report for a dropped misaligned entry
    always_ff @(posedge clk) begin
        if (reset_in) begin
            misalign_err  <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_err <= trap;
            if (trap) misalign_addr <= h_addr;
        end
    end
`else
    assign misalign_err  = 1'b0;
    assign misalign_addr = '0;
`endif
endmodule
